// File: rtl/jtdd_dwnld_buf.sv
// Download remapper: relocates loader bytes into the SDRAM layout and queues them in a
// small FIFO drained through a req/ack port. PROM bytes bypass the FIFO.
`timescale 1ns/1ps
module jtdd_dwnld_buf #(
  parameter logic [21:0] SCR_START  = 22'h5_8000,
  parameter logic [21:0] SCR_LEN    = 22'h2_0000,
  parameter logic [21:0] OBJ_START  = 22'h7_8000,
  parameter logic [21:0] OBJ_LEN    = 22'h4_0000,
  parameter logic [21:0] MCU_START  = 22'hB_8000,
  parameter logic [21:0] PROM_START = 22'hB_C000,
  parameter logic [21:0] SCR_ADDR   = 22'h4_0000,
  parameter logic [21:0] OBJ_ADDR   = 22'h8_0000,
  parameter logic [21:0] MCU_ADDR   = 22'hC_0000,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  input  logic        sdram_ack,
  output logic        prom_we,
  output logic [7:0]  prom_addr,
  output logic [3:0]  prom_data,
  output logic        dwnld_busy,
  output logic        overflow
);

  localparam logic [21:0] SCR_END  = SCR_START + SCR_LEN;
  localparam logic [21:0] OBJ_END  = OBJ_START + OBJ_LEN;
  localparam logic [21:0] PROM_END = PROM_START + 22'd256;
  localparam logic [21:0] SCR_HALF = SCR_LEN >> 1;
  localparam logic [21:0] OBJ_HALF = OBJ_LEN >> 1;
  localparam int unsigned DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = 1;

  // Address mapping
  logic [21:0] w_off, w_word;
  logic [1:0]  w_mask;
  logic        w_to_fifo, w_to_prom, w_wr;

  assign w_wr = ioctl_wr & downloading;

  always_comb begin
    w_off     = '0;
    w_word    = '0;
    w_mask    = 2'b11;
    w_to_fifo = 1'b0;
    w_to_prom = 1'b0;
    if (ioctl_addr < SCR_START) begin
      w_word    = ioctl_addr >> 1;
      w_mask    = ioctl_addr[0] ? 2'b01 : 2'b10;
      w_to_fifo = 1'b1;
    end else if (ioctl_addr < SCR_END) begin
      w_off     = ioctl_addr - SCR_START;
      w_to_fifo = 1'b1;
      // Lower half of the region lands on the low byte lane, upper half on the high lane
      if (w_off < SCR_HALF) begin
        w_word = SCR_ADDR + w_off;
        w_mask = 2'b10;
      end else begin
        w_word = SCR_ADDR + w_off - SCR_HALF;
        w_mask = 2'b01;
      end
    end else if (ioctl_addr >= OBJ_START && ioctl_addr < OBJ_END) begin
      w_off     = ioctl_addr - OBJ_START;
      w_to_fifo = 1'b1;
      if (w_off < OBJ_HALF) begin
        w_word = OBJ_ADDR + w_off;
        w_mask = 2'b10;
      end else begin
        w_word = OBJ_ADDR + w_off - OBJ_HALF;
        w_mask = 2'b01;
      end
    end else if (ioctl_addr >= MCU_START && ioctl_addr < PROM_START) begin
      w_off     = ioctl_addr - MCU_START;
      w_word    = MCU_ADDR + (w_off >> 1);
      w_mask    = w_off[0] ? 2'b01 : 2'b10;
      w_to_fifo = 1'b1;
    end else if (ioctl_addr >= PROM_START && ioctl_addr < PROM_END) begin
      w_to_prom = 1'b1;
    end
  end

  // Stage 1 registers
  logic        r_s1_valid;
  logic [21:0] r_s1_word;
  logic [7:0]  r_s1_data;
  logic [1:0]  r_s1_mask;
  logic        r_prom_we;
  logic [7:0]  r_prom_addr;
  logic [3:0]  r_prom_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_word   <= '0;
      r_s1_data   <= '0;
      r_s1_mask   <= 2'b11;
      r_prom_we   <= 1'b0;
      r_prom_addr <= '0;
      r_prom_data <= '0;
    end else begin
      r_s1_valid <= w_wr & w_to_fifo;
      r_prom_we  <= w_wr & w_to_prom;
      if (w_wr) begin
        r_s1_word <= w_word;
        r_s1_data <= ioctl_data;
        r_s1_mask <= w_mask;
      end
      if (w_wr && w_to_prom) begin
        r_prom_addr <= ioctl_addr[7:0];
        r_prom_data <= ioctl_data[3:0];
      end
    end
  end

  // Stage 2 FIFO; pointers carry an extra wrap bit to tell full from empty
  logic [21:0]      r_mem_word [DEPTH];
  logic [7:0]       r_mem_data [DEPTH];
  logic [1:0]       r_mem_mask [DEPTH];
  logic [FIFO_AW:0] r_wr_ptr, r_rd_ptr;
  logic             r_overflow, r_busy;
  logic             w_empty, w_full, w_pop, w_push, w_pending;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                   (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  assign w_pop   = !w_empty && sdram_ack;
  assign w_push  = r_s1_valid && (!w_full || w_pop);
  assign w_pending = r_s1_valid || !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_word[r_wr_ptr[FIFO_AW-1:0]] <= r_s1_word;
      r_mem_data[r_wr_ptr[FIFO_AW-1:0]] <= r_s1_data;
      r_mem_mask[r_wr_ptr[FIFO_AW-1:0]] <= r_s1_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (r_s1_valid && w_full && !w_pop) r_overflow <= 1'b1;
      r_busy <= downloading | w_pending;
    end
  end

  always_comb begin
    prog_we   = !w_empty;
    prog_addr = '0;
    prog_data = '0;
    prog_mask = 2'b11;
    if (!w_empty) begin
      prog_addr = r_mem_word[r_rd_ptr[FIFO_AW-1:0]];
      prog_data = r_mem_data[r_rd_ptr[FIFO_AW-1:0]];
      prog_mask = r_mem_mask[r_rd_ptr[FIFO_AW-1:0]];
    end
  end

  // Rise is registered; fall happens as soon as nothing is left in flight
  assign dwnld_busy = r_busy & (downloading | w_pending);
  assign overflow   = r_overflow;
  assign prom_we    = r_prom_we;
  assign prom_addr  = r_prom_addr;
  assign prom_data  = r_prom_data;

endmodule

// File: tb/tb_jtdd_dwnld_buf.sv
// Bench for jtdd_dwnld_buf: address-map vector table with scoreboard queues, plus sequences
// for FIFO overflow, busy drain timing and mid-download reset.
`timescale 1ns/1ps
module tb_jtdd_dwnld_buf;

  logic        clk, rst, downloading, ioctl_wr, sdram_ack;
  logic [21:0] ioctl_addr, prog_addr;
  logic [7:0]  ioctl_data, prog_data, prom_addr;
  logic [1:0]  prog_mask;
  logic        prog_we, prom_we, dwnld_busy, overflow;
  logic [3:0]  prom_data;

  jtdd_dwnld_buf dut (
    .clk        (clk),
    .rst        (rst),
    .downloading(downloading),
    .ioctl_addr (ioctl_addr),
    .ioctl_data (ioctl_data),
    .ioctl_wr   (ioctl_wr),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_mask  (prog_mask),
    .prog_we    (prog_we),
    .sdram_ack  (sdram_ack),
    .prom_we    (prom_we),
    .prom_addr  (prom_addr),
    .prom_data  (prom_data),
    .dwnld_busy (dwnld_busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [21:0] word; logic [7:0] data; logic [1:0] mask; } wr_t;
  typedef struct { logic [7:0] addr; logic [3:0] data; } prom_t;
  typedef struct {
    logic [21:0] addr; logic [7:0] data; int kind; logic [21:0] word; logic [1:0] mask;
  } vec_t;  // kind: 0 SDRAM write, 1 PROM write, 2 discarded

  wr_t   exp_q[$];
  prom_t prom_q[$];
  vec_t  vecs[17];
  int    n_checks = 0, n_fail = 0, n_writes = 0;
  bit    ack_en;
  int    ack_gap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event with nothing expected", name);
  endtask

  task automatic send(input logic [21:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(posedge clk); #1;
    ioctl_wr   = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int k = 0;
    while ((k < 4 || exp_q.size() != 0 || prom_q.size() != 0) && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, exp_q.size() + prom_q.size(), 0);
  endtask

  // SDRAM ack responder: ack after ack_gap cycles of prog_we
  initial begin
    int wcnt;
    sdram_ack = 1'b0;
    wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!ack_en || rst) begin
        sdram_ack = 1'b0;
        wcnt = 0;
      end else if (sdram_ack) begin
        sdram_ack = 1'b0;
        wcnt = prog_we ? 1 : 0;
      end else if (prog_we) begin
        if (wcnt >= ack_gap) sdram_ack = 1'b1;
        else wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  // Scoreboard: pop and compare on every accepted write and every PROM pulse
  initial begin
    wr_t e;
    prom_t p;
    forever begin
      @(negedge clk);
      if (prog_we && sdram_ack) begin
        n_writes++;
        if (exp_q.size() == 0) unexpected("prog_write");
        else begin
          e = exp_q.pop_front();
          check("prog_addr", prog_addr, e.word);
          check("prog_data", prog_data, e.data);
          check("prog_mask", prog_mask, e.mask);
        end
      end
      if (prom_we) begin
        if (prom_q.size() == 0) unexpected("prom_we");
        else begin
          p = prom_q.pop_front();
          check("prom_addr", prom_addr, p.addr);
          check("prom_data", prom_data, p.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, w0, bad, k;
    wr_t e;
    prom_t p;
    vecs[0]  = '{22'h000000, 8'h11, 0, 22'h000000, 2'b10};
    vecs[1]  = '{22'h000001, 8'h22, 0, 22'h000000, 2'b01};
    vecs[2]  = '{22'h012345, 8'h5A, 0, 22'h0091A2, 2'b01};
    vecs[3]  = '{22'h057FFF, 8'h99, 0, 22'h02BFFF, 2'b01};
    vecs[4]  = '{22'h068000, 8'hAB, 0, 22'h040000, 2'b01};
    vecs[5]  = '{22'h058005, 8'hCD, 0, 22'h040005, 2'b10};
    vecs[6]  = '{22'h077FFF, 8'hE1, 0, 22'h04FFFF, 2'b01};
    vecs[7]  = '{22'h078000, 8'h5E, 0, 22'h080000, 2'b10};
    vecs[8]  = '{22'h098003, 8'h42, 0, 22'h080003, 2'b01};
    vecs[9]  = '{22'h0B7FFF, 8'h0F, 0, 22'h09FFFF, 2'b01};
    vecs[10] = '{22'h0B8000, 8'hC3, 0, 22'h0C0000, 2'b10};
    vecs[11] = '{22'h0B8007, 8'hD4, 0, 22'h0C0003, 2'b01};
    vecs[12] = '{22'h0BBFFF, 8'hE5, 0, 22'h0C1FFF, 2'b01};
    vecs[13] = '{22'h0BC07F, 8'h3C, 1, 22'h00007F, 2'b11};
    vecs[14] = '{22'h0BC0FF, 8'hA5, 1, 22'h0000FF, 2'b11};
    vecs[15] = '{22'h0BC100, 8'h66, 2, 22'h000000, 2'b11};
    vecs[16] = '{22'h3FFFFF, 8'h77, 2, 22'h000000, 2'b11};

    rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_data = '0;
    ack_en = 1'b1; ack_gap = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_prog_we", prog_we, 0);
    check("rst_prom_we", prom_we, 0);
    check("rst_prog_addr", prog_addr, 0);
    check("rst_prog_data", prog_data, 0);
    check("rst_prog_mask", prog_mask, 2'b11);
    check("rst_busy", dwnld_busy, 0);
    check("rst_overflow", overflow, 0);

    // Strobes outside a download are ignored
    send(22'h000000, 8'h77);
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (prog_we || prom_we) seen++;
    end
    check("ignored_wr", seen, 0);
    check("ignored_busy", dwnld_busy, 0);

    downloading = 1'b1;
    check("busy_rise_same_cycle", dwnld_busy, 0);
    @(posedge clk); #1;
    check("busy_rise_next_cycle", dwnld_busy, 1);

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].kind == 0) begin
        e = '{vecs[i].word, vecs[i].data, vecs[i].mask};
        exp_q.push_back(e);
      end else if (vecs[i].kind == 1) begin
        p = '{vecs[i].word[7:0], vecs[i].data[3:0]};
        prom_q.push_back(p);
      end
      send(vecs[i].addr, vecs[i].data);
      if (i == 0) begin
        check("latency_n1", prog_we, 0);
        @(posedge clk); #1;
        check("latency_n2", prog_we, 1);
      end
      drain("vector_drain", 40);
    end

    // Overflow: ack held off, six strobes, only the first four survive
    ack_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        e.word = (22'h10 + 22'(i)) >> 1;
        e.data = 8'h60 + 8'(i);
        e.mask = (i % 2 == 1) ? 2'b01 : 2'b10;
        exp_q.push_back(e);
      end
      send(22'h10 + 22'(i), 8'h60 + 8'(i));
      @(posedge clk); #1;
      if (i == 3) begin
        check("ovf_before_fifth", overflow, 0);
        check("ovf_prog_we_held", prog_we, 1);
      end
      if (i == 4) check("ovf_after_fifth", overflow, 1);
    end
    check("ovf_head_frozen", prog_addr, 22'h8);
    w0 = n_writes;
    ack_en = 1'b1;
    drain("ovf_drain", 60);
    check("ovf_write_count", n_writes - w0, 4);
    check("ovf_sticky", overflow, 1);

    // Busy hold: three queued, last byte strobed on the final download cycle
    ack_en = 1'b0;
    ack_gap = 2;
    for (int i = 0; i < 3; i++) begin
      e.word = 22'hC0008 + 22'(i / 2);
      e.data = 8'h90 + 8'(i);
      e.mask = (i % 2 == 1) ? 2'b01 : 2'b10;
      exp_q.push_back(e);
      send(22'h0B8010 + 22'(i), 8'h90 + 8'(i));
      if (i == 2) downloading = 1'b0;
    end
    check("busy_after_last_strobe", dwnld_busy, 1);
    ack_en = 1'b1;
    w0 = n_writes;
    bad = 0;
    k = 0;
    while (n_writes - w0 < 3 && k < 60) begin
      @(negedge clk); #1;
      if (!dwnld_busy) bad++;
      k++;
    end
    check("busy_write_count", n_writes - w0, 3);
    check("busy_held_until_ack", bad, 0);
    @(posedge clk); #1;
    check("busy_fall", dwnld_busy, 0);

    // Reset with two entries pending
    ack_gap = 1;
    downloading = 1'b1;
    ack_en = 1'b0;
    send(22'h000100, 8'hF0);
    send(22'h000101, 8'hF1);
    @(posedge clk); #1;
    check("rst_mid_pending", prog_we, 1);
    rst = 1'b1;
    downloading = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_prog_we", prog_we, 0);
    check("rst_mid_busy", dwnld_busy, 0);
    check("rst_mid_overflow", overflow, 0);
    check("rst_mid_mask", prog_mask, 2'b11);
    ack_en = 1'b1;
    w0 = n_writes;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("rst_mid_no_writes", n_writes - w0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtdd_dwnld_buf.md
Name: jtdd_dwnld_buf

Overview:
- Download stage upstream of the game top level and SDRAM programming port.
- Takes the byte stream from the HPS/ioctl loader and remaps the file address into the reallocated SDRAM layout: scroll and object ROM halves byte-interleaved, MCU ROM relocated, priority PROM split off.
- Buffers remapped writes in a small FIFO and drains them to SDRAM with a req/ack handshake.
- Holds dwnld_busy until every byte has been committed.

Parameters:
- SCR_START, 22'h5_8000, file byte offset of scroll ROM region
- SCR_LEN, 22'h2_0000, scroll region size in bytes (even)
- OBJ_START, 22'h7_8000, file byte offset of object ROM region
- OBJ_LEN, 22'h4_0000, object region size in bytes (even)
- MCU_START, 22'hB_8000, file byte offset of MCU ROM
- PROM_START, 22'hB_C000, file byte offset of priority PROM (256 bytes)
- SCR_ADDR, 22'h4_0000, SDRAM word base for scroll
- OBJ_ADDR, 22'h8_0000, SDRAM word base for objects
- MCU_ADDR, 22'hC_0000, SDRAM word base for MCU
- FIFO_AW, 2, FIFO depth = 2**FIFO_AW entries

Ports:
- clk  in  1  48 MHz system clock
- rst  in  1  synchronous, active-high reset
- downloading  in  1  loader active
- ioctl_addr  in  22  file byte address
- ioctl_data  in  8  file byte
- ioctl_wr  in  1  one-cycle byte strobe
- prog_addr  out  22  SDRAM word address
- prog_data  out  8  byte; SDRAM duplicates it on both lanes
- prog_mask  out  2  active-low byte enable; 2'b10 = low byte, 2'b01 = high byte
- prog_we  out  1  write request, held until ack
- sdram_ack  in  1  SDRAM accepted current write
- prom_we  out  1  one-cycle PROM write pulse
- prom_addr  out  8  PROM address
- prom_data  out  4  PROM nibble (ioctl_data[3:0])
- dwnld_busy  out  1  download or drain in progress
- overflow  out  1  sticky: byte lost to full FIFO

Behaviour:
- Reset values: prog_we=0, prom_we=0, prog_addr=0, prog_data=0, prog_mask=2'b11, dwnld_busy=0, overflow=0. FIFO emptied, mapping stage invalid.
- ioctl_wr is ignored while downloading=0.
- Stage 1 (mapping), registered on the cycle after ioctl_wr. Let a=ioctl_addr.
  - a<SCR_START: word=a>>1; mask=a[0]?2'b01:2'b10.
  - SCR_START<=a<SCR_START+SCR_LEN: o=a-SCR_START; h=SCR_LEN/2.
    - o<h: word=SCR_ADDR+o, mask 2'b10.
    - otherwise: word=SCR_ADDR+o-h, mask 2'b01.
  - OBJ region: same rule as scroll, using OBJ_START/OBJ_LEN/OBJ_ADDR.
  - MCU_START<=a<PROM_START: o=a-MCU_START; word=MCU_ADDR+(o>>1); mask by o[0] as the first region.
  - PROM_START<=a<PROM_START+256: no FIFO entry. prom_we pulses exactly one cycle, at stage-1 time; prom_addr=a[7:0]; prom_data=ioctl_data[3:0].
  - a>=PROM_START+256, or any address not covered above: byte discarded, no effect.
- Stage 2 (FIFO), entries are {word, data, mask}.
  - Push on the cycle after stage 1 becomes valid.
  - A push while full with no simultaneous pop drops the entry and sets overflow (cleared only by rst).
  - Simultaneous push and pop when full is accepted.
  - Pointers wrap modulo 2**FIFO_AW; empty/full are distinguished by an extra pointer bit.
- Output handshake:
  - prog_we=1 whenever the FIFO is non-empty. prog_addr/prog_data/prog_mask show the head entry and are stable while prog_we=1.
  - The head pops on any cycle with prog_we&&sdram_ack. The next entry, if any, is presented on the following cycle with prog_we held high.
  - sdram_ack with prog_we=0 is ignored.
  - Minimum latency: ioctl_wr at cycle N gives prog_we=1 at N+2 when the FIFO is empty.
- dwnld_busy:
  - Rises the cycle after downloading=1.
  - Falls on the first cycle where downloading=0, stage 1 is invalid and the FIFO is empty.
  - A byte strobed on the last downloading cycle is still completed.
- Reset mid-download: all pending entries are dropped; outputs return to reset values the next cycle.

Test Plan:
- Bytes 0x11 @0x00000, 0x22 @0x00001, ack 1 cycle after each prog_we -> writes {0x00000,0x11,2'b10}, {0x00000,0x22,2'b01}; first prog_we 2 cycles after ioctl_wr.
- Byte 0xAB @SCR_START+0x10000 -> prog_addr=0x40000, mask 2'b01. Byte 0xCD @SCR_START+5 -> prog_addr=0x40005, mask 2'b10.
- Byte 0x3C @PROM_START+0x7F -> prom_we single pulse, prom_addr=0x7F, prom_data=4'hC, prog_we stays 0.
- sdram_ack held low, 6 consecutive ioctl_wr (each 2 cycles apart) -> 4 entries held, overflow=1 after the 5th, prog_addr frozen on first entry. Release ack -> exactly 4 writes in order.
- downloading falls with 3 entries queued, ack every 3rd cycle -> dwnld_busy stays 1 until the cycle after the 3rd ack, then 0.
- rst asserted with 2 entries queued -> next cycle prog_we=0, dwnld_busy=0, overflow=0, no further writes.
